bnn_seq_sched: RTL and testbench

BNN_SEQ_SCHED -- requirements
Module: bnn_seq_sched

---
 rtl/bnn_seq_sched.sv | 140 ++++++++++++++
 tb/tb_bnn_seq_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_sched.sv
// Scheduler that feeds one held sample at a time to a sequential BNN core and captures its class.
// Build option: define BNN_SEQ_SCHED_PREFETCH_EN to add a one-entry pending input buffer.
module bnn_seq_sched #(
  parameter int N   = 128,
  parameter int B   = 4,
  parameter int M   = 40,
  parameter int C   = 6,
  parameter int LAT = N + M + 1,
  localparam int KW = $clog2(C)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*B-1:0]  in_data,
  output logic            core_rst,
  output logic [N*B-1:0]  core_data,
  input  logic [KW-1:0]   core_klass,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [KW-1:0]   out_klass,
  output logic            busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          core_from_in, cnt_load, cnt_dec, out_set, out_clr;

`ifdef BNN_SEQ_SCHED_PREFETCH_EN
  logic [N*B-1:0] pend_data;
  logic           pend_full, pend_load, core_from_pend;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d      = state;
    in_ready     = 1'b0;
    core_rst     = 1'b1;
    core_from_in = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    out_set      = 1'b0;
    out_clr      = 1'b0;
`ifdef BNN_SEQ_SCHED_PREFETCH_EN
    pend_load      = 1'b0;
    core_from_pend = 1'b0;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          core_from_in = 1'b1;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        cnt_load = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        core_rst = 1'b0;
        if (cnt == '0) begin
          out_set = 1'b1;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BNN_SEQ_SCHED_PREFETCH_EN
    // Outside IDLE the buffer absorbs one sample; a DONE handshake restarts straight into CLEAR.
    if (state != IDLE) begin
      in_ready = !pend_full;
      if (state == DONE && out_ready && pend_full) begin
        core_from_pend = 1'b1;
        state_d        = CLEAR;
      end else if (state == DONE && out_ready && in_valid) begin
        core_from_in = 1'b1;
        state_d      = CLEAR;
      end else if (in_valid && !pend_full) begin
        pend_load = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      core_data <= '0;
      out_valid <= 1'b0;
      out_klass <= '0;
    end else begin
      if (cnt_load)     cnt <= CW'(LAT - 1);
      else if (cnt_dec) cnt <= cnt - CW'(1);
      if (core_from_in) core_data <= in_data;
`ifdef BNN_SEQ_SCHED_PREFETCH_EN
      else if (core_from_pend) core_data <= pend_data;
`endif
      if (out_set) begin
        out_valid <= 1'b1;
        out_klass <= core_klass;
      end else if (out_clr) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BNN_SEQ_SCHED_PREFETCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else if (pend_load) begin
      pend_full <= 1'b1;
      pend_data <= in_data;
    end else if (core_from_pend) begin
      pend_full <= 1'b0;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bnn_seq_sched.sv
// Scoreboard bench for bnn_seq_sched with a behavioural sequential core model.
module tb_bnn_seq_sched;
  localparam int N   = 128;
  localparam int B   = 4;
  localparam int M   = 40;
  localparam int C   = 6;
  localparam int LAT = N + M + 1;
  localparam int KW  = 3;
  localparam int W   = N * B;
`ifdef BNN_SEQ_SCHED_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, core_rst, out_valid, busy;
  logic [W-1:0]  core_data;
  logic [KW-1:0] core_klass, out_klass;

  typedef struct {
    logic [KW-1:0] k;
    int            t;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   ccnt = 0;
  int   lowc = 0;
  bit   ov_prev = 1'b0;
  int   kseq[4] = '{0, 2, 4, 1};

  always #5 clk = ~clk;

  bnn_seq_sched #(.N(N), .B(B), .M(M), .C(C), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_rst(core_rst), .core_data(core_data), .core_klass(core_klass),
    .out_valid(out_valid), .out_ready(out_ready), .out_klass(out_klass), .busy(busy)
  );

  // Core model: result is only correct once LAT cycles have elapsed since core reset release.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_rst) ccnt <= 0;
    else          ccnt <= ccnt + 1;
  end
  assign core_klass = (ccnt == LAT - 1) ? core_data[KW-1:0] : '1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic push(input int k, input int t);
    exp_t e;
    e.k = KW'(k);
    e.t = t;
    q.push_back(e);
  endtask

  function automatic logic [W-1:0] mk(input int k, input int s);
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = 32'h9E37_79B9 * 32'(s + i + 1);
    d[KW-1:0] = KW'(k);
    return d;
  endfunction

  task automatic wait_out(input int lim);
    for (int i = 0; i < lim && !out_valid; i++) @(negedge clk);
    chk("out_timeout", longint'(out_valid), 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!core_rst) lowc++;
    if (out_valid && !ov_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_klass", longint'(out_klass), longint'(e.k));
        chk("out_cycle", cyc, e.t);
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] da, db, de;
    int c0, cprev, base;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_klass", longint'(out_klass), 0);
    chk("rst_core_rst", longint'(core_rst), 1);
    chk("rst_core_data", longint'(core_data === '0), 1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Single sample, consumer always ready
    da = mk(3, 1);
    base = lowc;
    in_data = da;
    in_valid = 1'b1;
    c0 = cyc;
    chk("a_in_ready", longint'(in_ready), 1);
    push(3, c0 + LAT + 2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("a_clear_core_rst", longint'(core_rst), 1);
    chk("a_busy", longint'(busy), 1);
    chk("a_core_data", longint'(core_data === da), 1);
    repeat (60) @(negedge clk);
    chk("a_run_core_rst", longint'(core_rst), 0);
    chk("a_run_in_ready", longint'(in_ready), PF);
    chk("a_core_data_run", longint'(core_data === da), 1);
    wait_out(LAT + 10);
    chk("a_core_rst_low", lowc - base, LAT);
    @(negedge clk);
    chk("a_out_cleared", longint'(out_valid), 0);
    chk("a_idle", longint'(busy), 0);

    // Consumer stalls for 20 cycles
    out_ready = 1'b0;
    db = mk(5, 2);
    in_data = db;
    in_valid = 1'b1;
    c0 = cyc;
    push(5, c0 + LAT + 2);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(LAT + 10);
    for (int i = 0; i < 20; i++) begin
      if (PF == 0 && i == 5) begin
        in_data = mk(2, 9);
        in_valid = 1'b1;
      end
      if (i == 8) in_valid = 1'b0;
      @(negedge clk);
      chk("b_hold_valid", longint'(out_valid), 1);
      chk("b_hold_klass", longint'(out_klass), 5);
      chk("b_in_ready", longint'(in_ready), PF);
      chk("b_busy", longint'(busy), 1);
    end
    chk("b_core_data", longint'(core_data === db), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("b_out_cleared", longint'(out_valid), 0);
    chk("b_idle", longint'(busy), 0);

    // Reset asserted in RUN cycle 50 discards the inference
    in_data = mk(1, 3);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("c_in_run", longint'(core_rst), 0);
    rst = 1'b0;
    #1;
    chk("c_busy", longint'(busy), 0);
    chk("c_out_valid", longint'(out_valid), 0);
    chk("c_core_rst", longint'(core_rst), 1);
    chk("c_core_data", longint'(core_data === '0), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    chk("c_no_result", longint'(out_valid), 0);
    chk("c_queue", q.size(), 0);

    if (PF == 0) begin
      // Back-to-back samples with in_valid held high
      cprev = 0;
      for (int s = 0; s < 4; s++) begin
        in_data = mk(kseq[s], 10 + s);
        in_valid = 1'b1;
        for (int i = 0; i < 2 * LAT && !in_ready; i++) @(negedge clk);
        chk("d_in_ready", longint'(in_ready), 1);
        if (s > 0) chk("d_spacing", cyc - cprev, LAT + 3);
        cprev = cyc;
        push(kseq[s], cyc + LAT + 2);
        @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2 * LAT && q.size() != 0; i++) @(negedge clk);
      chk("d_drain", q.size(), 0);
      @(negedge clk);
    end else begin
      // Prefetch: second sample buffered during RUN, third stalls while buffer full
      in_data = mk(2, 20);
      in_valid = 1'b1;
      c0 = cyc;
      push(2, c0 + LAT + 2);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      de = mk(4, 21);
      in_data = de;
      in_valid = 1'b1;
      chk("e_accept", longint'(in_ready), 1);
      push(4, c0 + 2 * LAT + 4);
      @(negedge clk);
      in_data = mk(5, 22);
      push(5, c0 + 3 * LAT + 6);
      while (cyc < c0 + LAT + 3) begin
        chk("e_stall", longint'(in_ready), 0);
        @(negedge clk);
      end
      chk("e_clear_core_rst", longint'(core_rst), 1);
      chk("e_clear_busy", longint'(busy), 1);
      chk("e_core_data", longint'(core_data === de), 1);
      chk("e_third_ready", longint'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3 * LAT && q.size() != 0; i++) @(negedge clk);
      chk("e_drain", q.size(), 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
